bus_xfer_decoder: RTL

Sequences register-to-register transfers over the shared 32-bit datapath bus. It turns 5-bit source and destination codes into one-hot bus-out and register-in enables. It is the decode end of the 32-input bus mux and its 32-to-5 select encoder: it drives exactly the one-hot out-enable that the encoder compresses back into the mux select. Requests are buffered in a small FIFO and issued one bus transfer at a time, with a configurable settle interval before the destination latch.

---
 rtl/bus_xfer_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bus_xfer_decoder.sv
// bus_xfer_decoder: queues register-to-register bus transfer requests and
// issues them one at a time. Each transfer holds a one-hot bus-out enable for
// SETTLE cycles and pulses the one-hot register-in enable in the last of them.
//
// Ports:
//   clock      rising-edge clock
//   clear      synchronous active-low reset
//   req_valid  request offered
//   req_src    5-bit source register code
//   req_dst    5-bit destination register code
//   req_ready  request can be accepted (FIFO not full)
//   out_en     one-hot bus-out enable (bit = src code), held for the transfer
//   in_en      one-hot register-in enable (bit = dst code), latch cycle only
//   busy       transfer in progress or requests queued
//   xfer_done  pulse on a transfer's latch cycle
//   req_err    pulse one cycle after an invalid request is accepted
`timescale 1ns/1ps

package bus_xfer_pkg;
  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
  } xfer_t;
endpackage

module bus_xfer_decoder
  import bus_xfer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  output logic        req_ready,
  output logic [31:0] out_en,
  output logic [31:0] in_en,
  output logic        busy,
  output logic        xfer_done,
  output logic        req_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = AW + 1;
  localparam int unsigned CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  // Sources: R0-R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C.
  function automatic logic src_ok(input logic [4:0] code);
    return code < 5'd24;
  endfunction

  // Destinations: R0-R15, HI, LO, PC, MDR (ZHI/ZLO/InPort/C are read-only).
  function automatic logic dst_ok(input logic [4:0] code);
    return (code <= 5'd17) || (code == 5'd20) || (code == 5'd21);
  endfunction

  xfer_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count, count_nxt;
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  xfer_t           cur, cur_nxt;
  logic            accept, req_ok, push, pop;
  logic [31:0]     out_en_nxt, in_en_nxt;
  logic            busy_nxt, xfer_done_nxt;

  assign req_ready = (count != COUNT_FULL);
  assign accept    = req_valid & req_ready;
  assign req_ok    = src_ok(req_src) & dst_ok(req_dst);
  assign push      = accept & req_ok;

  // Request storage; only valid requests are written.
  always_ff @(posedge clock) begin
    if (clear && push) begin
      mem[wr_ptr] <= '{src: req_src, dst: req_dst};
    end
  end

  // State, FIFO pointers and registered outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_en    <= '0;
      in_en     <= '0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur       <= cur_nxt;
      count     <= count_nxt;
      out_en    <= out_en_nxt;
      in_en     <= in_en_nxt;
      busy      <= busy_nxt;
      xfer_done <= xfer_done_nxt;
      req_err   <= accept & ~req_ok;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Next state, FIFO pop and next-cycle output decode.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cur_nxt       = cur;
    pop           = 1'b0;
    count_nxt     = count;
    out_en_nxt    = '0;
    in_en_nxt     = '0;
    busy_nxt      = 1'b0;
    xfer_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          cur_nxt   = mem[rd_ptr];
          cnt_nxt   = '0;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + CW'(1);
        end else if (count != '0) begin
          // Latch cycle with work queued: chain straight into the next transfer.
          pop     = 1'b1;
          cur_nxt = mem[rd_ptr];
          cnt_nxt = '0;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_nxt = count + NW'(1);
      2'b01:   count_nxt = count - NW'(1);
      default: count_nxt = count;
    endcase

    if (state_nxt == DRIVE) begin
      out_en_nxt = 32'(1) << cur_nxt.src;
      if (cnt_nxt == CNT_LAST) begin
        in_en_nxt     = 32'(1) << cur_nxt.dst;
        xfer_done_nxt = 1'b1;
      end
    end
    busy_nxt = (state_nxt == DRIVE) || (count_nxt != '0);
  end

endmodule
